// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipeline control for the 5-stage MIPS core.
// Decodes the ID instruction, carries its control bundle through the
// EX/MEM/WB registers, and detects load-use/RAW hazards (stall + bubble).
// Optional feature macro: PIPE_FORWARD_EN (EX operand forwarding selects,
// only load-use stalls). Without it there is a full RAW interlock on EX/MEM.
module pipe_ctrl_unit #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 5,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_id,
    input  logic               id_valid,
    input  logic               flush,
    output logic [1:0]         ext_op,
    output logic               br_signal,
    output logic               jmp_signal,
    output logic               jmpr_signal,
    output logic               stall,
    output logic               ex_reg_wr,
    output logic               ex_mem_read,
    output logic               ex_bsel,
    output logic [1:0]         ex_asel,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               mem_reg_wr,
    output logic               mem_dm_wr,
    output logic [1:0]         mem_be,
    output logic [1:0]         mem_wsel,
    output logic [REG_AW-1:0]  mem_rd,
    output logic               wb_reg_wr,
    output logic [1:0]         wb_wsel,
    output logic [REG_AW-1:0]  wb_rd
`ifdef PIPE_FORWARD_EN
    ,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
`endif
);

    // ALU operation encodings
    localparam logic [ALUOP_W-1:0] ALUOp_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALUOp_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALUOp_AND  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALUOp_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALUOp_XOR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALUOp_NOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALUOp_SLT  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALUOp_SLTU = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALUOp_SLL  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALUOp_SRL  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALUOp_SRA  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALUOp_ADDU = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] ALUOp_SUBU = ALUOP_W'(13);

    // Byte-enable codes; BE_SW is also the idle/reset value
    localparam logic [1:0] BE_SW = 2'b00;
    localparam logic [1:0] BE_SH = 2'b01;
    localparam logic [1:0] BE_SB = 2'b10;

    // Write-back source selects
    localparam logic [1:0] WSEL_ALU  = 2'b00;
    localparam logic [1:0] WSEL_MEM  = 2'b01;
    localparam logic [1:0] WSEL_LINK = 2'b10;

    // Instruction fields at standard MIPS positions
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] idRs;
    logic [REG_AW-1:0] idRt;
    logic [REG_AW-1:0] idRdField;
    logic              unusedShamt;

    assign opcode      = instr_id[31:26];
    assign funct       = instr_id[5:0];
    assign idRs        = instr_id[21 +: REG_AW];
    assign idRt        = instr_id[16 +: REG_AW];
    assign idRdField   = instr_id[11 +: REG_AW];
    assign unusedShamt = ^instr_id[10:6];   // shamt is consumed by the datapath, not here

    // Decoded ID control bundle
    logic               idRegWr;
    logic               idMemRead;
    logic               idDmWr;
    logic [1:0]         idBe;
    logic               idBsel;
    logic [1:0]         idAsel;
    logic [ALUOP_W-1:0] idAluop;
    logic [REG_AW-1:0]  idRd;
    logic [1:0]         idWsel;
    logic               usesRs;
    logic               usesRt;

    // Combinational decode; everything defaulted first so nothing latches
    always_comb begin
        ext_op      = 2'b00;
        br_signal   = 1'b0;
        jmp_signal  = 1'b0;
        jmpr_signal = 1'b0;
        idRegWr     = 1'b0;
        idMemRead   = 1'b0;
        idDmWr      = 1'b0;
        idBe        = BE_SW;
        idBsel      = 1'b0;
        idAsel      = 2'b00;
        idAluop     = ALUOp_ADD;
        idRd        = '0;
        idWsel      = WSEL_ALU;
        usesRs      = 1'b1;
        usesRt      = 1'b0;
        case (opcode)
            6'h00: begin
                usesRt  = 1'b1;
                idRd    = idRdField;
                idRegWr = 1'b1;
                case (funct)
                    6'h00: begin idAluop = ALUOp_SLL; idAsel = 2'b10; usesRs = 1'b0; end
                    6'h02: begin idAluop = ALUOp_SRL; idAsel = 2'b10; usesRs = 1'b0; end
                    6'h03: begin idAluop = ALUOp_SRA; idAsel = 2'b10; usesRs = 1'b0; end
                    6'h04: idAluop = ALUOp_SLL;
                    6'h06: idAluop = ALUOp_SRL;
                    6'h07: idAluop = ALUOp_SRA;
                    6'h08: begin jmpr_signal = 1'b1; idRegWr = 1'b0; end
                    6'h09: begin jmpr_signal = 1'b1; idWsel = WSEL_LINK; end
                    6'h20: idAluop = ALUOp_ADD;
                    6'h21: idAluop = ALUOp_ADDU;
                    6'h22: idAluop = ALUOp_SUB;
                    6'h23: idAluop = ALUOp_SUBU;
                    6'h24: idAluop = ALUOp_AND;
                    6'h25: idAluop = ALUOp_OR;
                    6'h26: idAluop = ALUOp_XOR;
                    6'h27: idAluop = ALUOp_NOR;
                    6'h2A: idAluop = ALUOp_SLT;
                    6'h2B: idAluop = ALUOp_SLTU;
                    default: idRegWr = 1'b0;
                endcase
            end
            6'h02: begin jmp_signal = 1'b1; usesRs = 1'b0; end
            6'h03: begin
                jmp_signal = 1'b1;
                usesRs     = 1'b0;
                idRegWr    = 1'b1;
                idRd       = REG_AW'(31);
                idWsel     = WSEL_LINK;
            end
            6'h04, 6'h05: begin
                br_signal = 1'b1;
                ext_op    = 2'b01;
                usesRt    = 1'b1;
                idAluop   = ALUOp_SUB;
            end
            6'h01, 6'h06, 6'h07: begin br_signal = 1'b1; ext_op = 2'b01; end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                ext_op  = 2'b01;
                idRegWr = 1'b1;
                idRd    = idRt;
                idBsel  = 1'b1;
                idAluop = (opcode == 6'h0A) ? ALUOp_SLT :
                          (opcode == 6'h0B) ? ALUOp_SLTU : ALUOp_ADD;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                idRegWr = 1'b1;
                idRd    = idRt;
                idBsel  = 1'b1;
                idAluop = (opcode == 6'h0C) ? ALUOp_AND :
                          (opcode == 6'h0D) ? ALUOp_OR : ALUOp_XOR;
            end
            6'h0F: begin
                // LUI: immediate shifted left by the constant 16
                usesRs  = 1'b0;
                idRegWr = 1'b1;
                idRd    = idRt;
                idBsel  = 1'b1;
                idAsel  = 2'b01;
                idAluop = ALUOp_SLL;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                ext_op    = 2'b01;
                idRegWr   = 1'b1;
                idMemRead = 1'b1;
                idRd      = idRt;
                idBsel    = 1'b1;
                idWsel    = WSEL_MEM;
            end
            6'h28, 6'h29, 6'h2B: begin
                ext_op = 2'b01;
                idDmWr = 1'b1;
                idBsel = 1'b1;
                usesRt = 1'b1;
                idBe   = (opcode == 6'h28) ? BE_SB :
                         (opcode == 6'h29) ? BE_SH : BE_SW;
            end
            default: usesRs = 1'b1;
        endcase
    end

    // Hazard detection against the instructions in EX and MEM
    logic matchEx;
    logic matchMem;
    logic bubble;

    assign matchEx  = ex_reg_wr && (ex_rd != '0) &&
                      ((usesRs && ex_rd == idRs) || (usesRt && ex_rd == idRt));
    assign matchMem = mem_reg_wr && (mem_rd != '0) &&
                      ((usesRs && mem_rd == idRs) || (usesRt && mem_rd == idRt));

`ifdef PIPE_FORWARD_EN
    assign stall = id_valid && ex_mem_read && matchEx;
`else
    assign stall = id_valid && (matchEx || matchMem);
`endif

    assign bubble = stall || flush || !id_valid;

    // EX-stage internals not exported as ports
    logic       exDmWr;
    logic [1:0] exBe;
    logic [1:0] exWsel;

    // ID/EX register: loads the decoded bundle, or all-zero controls on a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bubble) begin
            ex_reg_wr   <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_bsel     <= 1'b0;
            ex_asel     <= 2'b00;
            ex_aluop    <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            exDmWr      <= 1'b0;
            exBe        <= BE_SW;
            exWsel      <= WSEL_ALU;
        end else begin
            ex_reg_wr   <= idRegWr;
            ex_mem_read <= idMemRead;
            ex_bsel     <= idBsel;
            ex_asel     <= idAsel;
            ex_aluop    <= idAluop;
            ex_rs       <= idRs;
            ex_rt       <= idRt;
            ex_rd       <= idRd;
            exDmWr      <= idDmWr;
            exBe        <= idBe;
            exWsel      <= idWsel;
        end
    end

    // EX/MEM and MEM/WB registers always advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_reg_wr <= 1'b0;
            mem_dm_wr  <= 1'b0;
            mem_be     <= BE_SW;
            mem_wsel   <= WSEL_ALU;
            mem_rd     <= '0;
            wb_reg_wr  <= 1'b0;
            wb_wsel    <= WSEL_ALU;
            wb_rd      <= '0;
        end else begin
            mem_reg_wr <= ex_reg_wr;
            mem_dm_wr  <= exDmWr;
            mem_be     <= exBe;
            mem_wsel   <= exWsel;
            mem_rd     <= ex_rd;
            wb_reg_wr  <= mem_reg_wr;
            wb_wsel    <= mem_wsel;
            wb_rd      <= mem_rd;
        end
    end

`ifdef PIPE_FORWARD_EN
    // Operand forwarding selects: index 0 is operand A (ex_rs), 1 is B (ex_rt)
    logic [2*REG_AW-1:0] srcAddr;
    logic [3:0]          fwdSel;

    assign srcAddr = {ex_rt, ex_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [REG_AW-1:0] src;
            assign src = srcAddr[gi*REG_AW +: REG_AW];
            // MEM is younger than WB, so it wins; $0 never forwards
            assign fwdSel[gi*2 +: 2] =
                (mem_reg_wr && mem_rd != '0 && mem_rd == src) ? 2'b10 :
                (wb_reg_wr  && wb_rd  != '0 && wb_rd  == src) ? 2'b01 : 2'b00;
        end
    endgenerate

    assign fwd_a = fwdSel[1:0];
    assign fwd_b = fwdSel[3:2];
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed testbench for pipe_ctrl_unit (works with or without PIPE_FORWARD_EN).
module tb_pipe_ctrl_unit;

    // Expected encodings, written out independently
    localparam logic [31:0] A_ADDU = 32'd12;
    localparam logic [31:0] A_SLTU = 32'd7;
    localparam logic [31:0] A_SLL  = 32'd8;
    localparam logic [31:0] A_SUB  = 32'd1;
    localparam logic [31:0] BE_SW  = 32'd0;
    localparam logic [31:0] BE_SB  = 32'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_id;
    logic        id_valid;
    logic        flush;
    logic [1:0]  ext_op;
    logic        br_signal, jmp_signal, jmpr_signal, stall;
    logic        ex_reg_wr, ex_mem_read, ex_bsel;
    logic [1:0]  ex_asel;
    logic [4:0]  ex_aluop, ex_rs, ex_rt, ex_rd;
    logic        mem_reg_wr, mem_dm_wr;
    logic [1:0]  mem_be, mem_wsel;
    logic [4:0]  mem_rd;
    logic        wb_reg_wr;
    logic [1:0]  wb_wsel;
    logic [4:0]  wb_rd;
`ifdef PIPE_FORWARD_EN
    logic [1:0]  fwd_a, fwd_b;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid), .flush(flush),
        .ext_op(ext_op), .br_signal(br_signal), .jmp_signal(jmp_signal),
        .jmpr_signal(jmpr_signal), .stall(stall),
        .ex_reg_wr(ex_reg_wr), .ex_mem_read(ex_mem_read), .ex_bsel(ex_bsel),
        .ex_asel(ex_asel), .ex_aluop(ex_aluop), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .mem_reg_wr(mem_reg_wr), .mem_dm_wr(mem_dm_wr), .mem_be(mem_be),
        .mem_wsel(mem_wsel), .mem_rd(mem_rd),
        .wb_reg_wr(wb_reg_wr), .wb_wsel(wb_wsel), .wb_rd(wb_rd)
`ifdef PIPE_FORWARD_EN
        , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Apply ID inputs shortly after a rising edge and let decode settle
    task automatic drive(input logic [31:0] ins, input logic v, input logic f);
        instr_id = ins;
        id_valid = v;
        flush    = f;
        #1;
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drain;
        drive(32'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        id_valid = 1'b1;
        instr_id = $urandom;
        repeat (3) tick();

        // Reset state
        check("rst_ex_reg_wr",  32'(ex_reg_wr), 0);
        check("rst_ex_memread", 32'(ex_mem_read), 0);
        check("rst_ex_aluop",   32'(ex_aluop), 0);
        check("rst_ex_rd",      32'(ex_rd), 0);
        check("rst_mem_reg_wr", 32'(mem_reg_wr), 0);
        check("rst_mem_dm_wr",  32'(mem_dm_wr), 0);
        check("rst_mem_be",     32'(mem_be), BE_SW);
        check("rst_wb_reg_wr",  32'(wb_reg_wr), 0);
        check("rst_wb_rd",      32'(wb_rd), 0);
        check("rst_stall",      32'(stall), 0);

        // ADDU $3,$1,$2 travels EX -> MEM -> WB
        rst = 1'b1;
        drive(rtype(1, 2, 3, 0, 6'h21), 1'b1, 1'b0);
        tick();
        check("addu_ex_rd",     32'(ex_rd), 3);
        check("addu_ex_reg_wr", 32'(ex_reg_wr), 1);
        check("addu_ex_aluop",  32'(ex_aluop), A_ADDU);
        drive(32'd0, 1'b0, 1'b0);
        tick();
        check("addu_mem_rd",    32'(mem_rd), 3);
        check("addu_mem_reg_wr", 32'(mem_reg_wr), 1);
        tick();
        check("addu_wb_reg_wr", 32'(wb_reg_wr), 1);
        check("addu_wb_wsel",   32'(wb_wsel), 0);
        check("addu_wb_rd",     32'(wb_rd), 3);
        check("idle_ex_reg_wr", 32'(ex_reg_wr), 0);
        drain();

        // Load-use: LW $4,0($1) ; ADD $5,$4,$2
        drive(itype(6'h23, 1, 4, 0), 1'b1, 1'b0);
        tick();
        check("lw_ex_memread",  32'(ex_mem_read), 1);
        drive(rtype(4, 2, 5, 0, 6'h20), 1'b1, 1'b0);
        check("lu_stall1",      32'(stall), 1);
        tick();
        check("lu_bubble_wr",   32'(ex_reg_wr), 0);
        check("lu_bubble_rd",   32'(ex_mem_read), 0);
`ifdef PIPE_FORWARD_EN
        check("lu_stall2",      32'(stall), 0);
        tick();
        check("lu_ex_rd",       32'(ex_rd), 5);
        check("lu_fwd_a",       32'(fwd_a), 1);
        check("lu_fwd_b",       32'(fwd_b), 0);
`else
        check("lu_stall2",      32'(stall), 1);
        tick();
        check("lu_stall3",      32'(stall), 0);
        tick();
        check("lu_ex_rd",       32'(ex_rd), 5);
`endif
        drain();

        // RAW on an ALU result: ADDU $8,$1,$2 ; OR $9,$8,$0
        drive(rtype(1, 2, 8, 0, 6'h21), 1'b1, 1'b0);
        check("raw_stall0",     32'(stall), 0);
        tick();
        drive(rtype(8, 0, 9, 0, 6'h25), 1'b1, 1'b0);
`ifdef PIPE_FORWARD_EN
        check("raw_stall1",     32'(stall), 0);
        tick();
        check("raw_ex_rd",      32'(ex_rd), 9);
`else
        check("raw_stall1",     32'(stall), 1);
        tick();
        check("raw_bubble",     32'(ex_reg_wr), 0);
        check("raw_stall2",     32'(stall), 1);
        tick();
        check("raw_stall3",     32'(stall), 0);
        tick();
        check("raw_ex_rd",      32'(ex_rd), 9);
        check("raw_ex_reg_wr",  32'(ex_reg_wr), 1);
`endif
        drain();

`ifdef PIPE_FORWARD_EN
        // Forward priority: ADDU $6 ; ADDU $6 ; SUB $7,$6,$6
        drive(rtype(1, 2, 6, 0, 6'h21), 1'b1, 1'b0);
        tick();
        drive(rtype(3, 4, 6, 0, 6'h21), 1'b1, 1'b0);
        tick();
        drive(rtype(6, 6, 7, 0, 6'h22), 1'b1, 1'b0);
        check("fp_stall",       32'(stall), 0);
        tick();
        check("fp_ex_aluop",    32'(ex_aluop), A_SUB);
        check("fp_fwd_a",       32'(fwd_a), 2);
        check("fp_fwd_b",       32'(fwd_b), 2);
        drain();
`endif

        // Flush: BEQ $1,$2 then squashed ORI and SW
        drive(itype(6'h04, 1, 2, 4), 1'b1, 1'b0);
        check("beq_br",         32'(br_signal), 1);
        check("beq_ext",        32'(ext_op), 1);
        tick();
        drive(itype(6'h0D, 1, 10, 5), 1'b1, 1'b1);
        tick();
        check("fl_ex_reg_wr",   32'(ex_reg_wr), 0);
        check("fl_ex_memread",  32'(ex_mem_read), 0);
        drive(itype(6'h2B, 1, 5, 0), 1'b1, 1'b1);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        tick();
        check("fl_mem_dm_wr",   32'(mem_dm_wr), 0);
        drain();

        // Decode edges
        drive(itype(6'h0B, 1, 11, 7), 1'b1, 1'b0);
        check("sltiu_ext",      32'(ext_op), 1);
        tick();
        check("sltiu_aluop",    32'(ex_aluop), A_SLTU);
        check("sltiu_bsel",     32'(ex_bsel), 1);
        drive(itype(6'h0C, 1, 12, 3), 1'b1, 1'b0);
        check("andi_ext",       32'(ext_op), 0);
        drive(rtype(0, 1, 14, 3, 6'h00), 1'b1, 1'b0);
        tick();
        check("sll_asel",       32'(ex_asel), 2);
        check("sll_aluop",      32'(ex_aluop), A_SLL);
        drive(itype(6'h0F, 0, 13, 16'h1234), 1'b1, 1'b0);
        check("lui_ext",        32'(ext_op), 0);
        tick();
        check("lui_asel",       32'(ex_asel), 1);
        drain();

        drive({6'h03, 26'h100}, 1'b1, 1'b0);
        check("jal_jmp",        32'(jmp_signal), 1);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("jal_wb_rd",      32'(wb_rd), 31);
        check("jal_wb_wsel",    32'(wb_wsel), 2);
        drain();

        drive(rtype(31, 0, 0, 0, 6'h08), 1'b1, 1'b0);
        check("jr_jmpr",        32'(jmpr_signal), 1);
        tick();
        check("jr_no_write",    32'(ex_reg_wr), 0);
        drain();

        drive(itype(6'h2B, 1, 5, 4), 1'b1, 1'b0);
        tick();
        drive(itype(6'h28, 1, 5, 0), 1'b1, 1'b0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        check("sw_mem_dm_wr",   32'(mem_dm_wr), 1);
        check("sw_mem_reg_wr",  32'(mem_reg_wr), 0);
        check("sw_mem_be",      32'(mem_be), BE_SW);
        tick();
        check("sb_mem_be",      32'(mem_be), BE_SB);
        drain();

        // Write to $0 never causes a stall
        drive(rtype(1, 2, 0, 0, 6'h21), 1'b1, 1'b0);
        tick();
        drive(rtype(0, 0, 9, 0, 6'h25), 1'b1, 1'b0);
        check("zero_no_stall",  32'(stall), 0);
        drain();

        // Asynchronous reset mid-stream empties the pipeline without a clock
        drive(rtype(1, 2, 3, 0, 6'h21), 1'b1, 1'b0);
        tick();
        check("ar_ex_before",   32'(ex_reg_wr), 1);
        rst = 1'b0;
        #1;
        check("ar_ex_after",    32'(ex_reg_wr), 0);
        check("ar_ex_rd",       32'(ex_rd), 0);
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0);
        tick();
        check("ar_mem_empty",   32'(mem_reg_wr), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
